// File: rtl/remote_channel_sequencer_pkg.sv
// Shared types and constants for the remote stick-channel sequencer.
// Default timing constants assume a 27 MHz system clock.
package remote_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM_LOW  = 3'd1,
    ST_ARM_HIGH = 3'd2,
    ST_ARM_REL  = 3'd3,
    ST_FLY      = 3'd4,
    ST_FAILSAFE = 3'd5
  } state_t;

  localparam logic [7:0] NEUTRAL = 8'd128;
  localparam logic [7:0] TH_MIN  = 8'd0;
  localparam logic [7:0] TH_MAX  = 8'd255;

  localparam int unsigned DEF_CNT_W              = 26;
  localparam int unsigned DEF_ARM_LOW_CYCLES     = 28_000_000;
  localparam int unsigned DEF_ARM_HIGH_CYCLES    = 26_000_000;
  localparam int unsigned DEF_CMD_TIMEOUT_CYCLES = 13_500_000;
  localparam int unsigned DEF_RAMP_DIV           = 270_000;

  typedef struct packed {
    logic [7:0] throttle;
    logic [7:0] yaw;
    logic [7:0] pitch;
    logic [7:0] roll;
  } chan_t;

  function automatic chan_t idle_chans(input logic [7:0] centre);
    chan_t c;
    c.throttle = TH_MIN;
    c.yaw      = centre;
    c.pitch    = centre;
    c.roll     = centre;
    return c;
  endfunction

endpackage

// File: rtl/remote_channel_sequencer_phase_timer.sv
// Loadable up-counter with clear and enable; done flags count == terminal.
// Shared by the arm phases, the command watchdog and the failsafe ramp divider.
module phase_timer #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] load_value,
  input  logic [CNT_W-1:0] terminal,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = (count == terminal);

endmodule

// File: rtl/remote_channel_sequencer.sv
// Arms the transmitter with a low/full/low throttle stroke, then forwards
// gesture commands with a watchdog, a throttle-ramp failsafe and disarm.
module remote_channel_sequencer #(
  parameter int unsigned CNT_W              = remote_pkg::DEF_CNT_W,
  parameter int unsigned ARM_LOW_CYCLES     = remote_pkg::DEF_ARM_LOW_CYCLES,
  parameter int unsigned ARM_HIGH_CYCLES    = remote_pkg::DEF_ARM_HIGH_CYCLES,
  parameter int unsigned CMD_TIMEOUT_CYCLES = remote_pkg::DEF_CMD_TIMEOUT_CYCLES,
  parameter int unsigned RAMP_DIV           = remote_pkg::DEF_RAMP_DIV,
  parameter logic [7:0]  NEUTRAL            = remote_pkg::NEUTRAL
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       on_pulse,
  input  logic       off_pulse,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_throttle,
  input  logic [7:0] cmd_yaw,
  input  logic [7:0] cmd_pitch,
  input  logic [7:0] cmd_roll,
  output logic [7:0] ch_throttle,
  output logic [7:0] ch_yaw,
  output logic [7:0] ch_pitch,
  output logic [7:0] ch_roll,
  output logic       armed,
  output logic       failsafe,
  output logic [2:0] state_dbg
);

  import remote_pkg::state_t;
  import remote_pkg::chan_t;
  import remote_pkg::idle_chans;
  import remote_pkg::TH_MIN;
  import remote_pkg::TH_MAX;
  import remote_pkg::ST_IDLE;
  import remote_pkg::ST_ARM_LOW;
  import remote_pkg::ST_ARM_HIGH;
  import remote_pkg::ST_ARM_REL;
  import remote_pkg::ST_FLY;
  import remote_pkg::ST_FAILSAFE;

  localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_W;

  if (ARM_LOW_CYCLES == 0 || ARM_HIGH_CYCLES == 0 || CMD_TIMEOUT_CYCLES == 0 ||
      RAMP_DIV == 0 ||
      longint'(ARM_LOW_CYCLES) > CNT_LIMIT || longint'(ARM_HIGH_CYCLES) > CNT_LIMIT ||
      longint'(CMD_TIMEOUT_CYCLES) > CNT_LIMIT || longint'(RAMP_DIV) > CNT_LIMIT)
  begin : g_param_check
    $error("remote_channel_sequencer: timing parameters must be 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] TC_ARM_LOW  = CNT_W'(ARM_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] TC_ARM_HIGH = CNT_W'(ARM_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TC_TIMEOUT  = CNT_W'(CMD_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TC_RAMP     = CNT_W'(RAMP_DIV - 1);

  state_t           state, state_next;
  chan_t            ch, ch_next;
  logic             t_clear, t_load, t_enable, t_done;
  logic [CNT_W-1:0] t_load_value, t_terminal;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (t_clear),
    .load       (t_load),
    .enable     (t_enable),
    .load_value (t_load_value),
    .terminal   (t_terminal),
    .done       (t_done)
  );

  always_comb begin
    t_terminal = '0;
    unique case (state)
      ST_ARM_LOW:  t_terminal = TC_ARM_LOW;
      ST_ARM_HIGH: t_terminal = TC_ARM_HIGH;
      ST_FLY:      t_terminal = TC_TIMEOUT;
      ST_FAILSAFE: t_terminal = TC_RAMP;
      default:     t_terminal = '0;
    endcase
  end

  assign cmd_ready = (state == ST_FLY);

  always_comb begin
    state_next   = state;
    ch_next      = ch;
    t_clear      = 1'b0;
    t_load       = 1'b0;
    t_enable     = 1'b0;
    t_load_value = '0;

    if (off_pulse) begin
      state_next = ST_IDLE;
      ch_next    = idle_chans(NEUTRAL);
      t_clear    = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          ch_next = idle_chans(NEUTRAL);
          t_clear = 1'b1;
          if (on_pulse) state_next = ST_ARM_LOW;
        end
        ST_ARM_LOW: begin
          ch_next.throttle = TH_MIN;
          if (t_done) begin
            state_next       = ST_ARM_HIGH;
            ch_next.throttle = TH_MAX;
            t_clear          = 1'b1;
          end else begin
            t_enable = 1'b1;
          end
        end
        ST_ARM_HIGH: begin
          ch_next.throttle = TH_MAX;
          if (t_done) begin
            state_next       = ST_ARM_REL;
            ch_next.throttle = TH_MIN;
            t_clear          = 1'b1;
          end else begin
            t_enable = 1'b1;
          end
        end
        ST_ARM_REL: begin
          state_next       = ST_FLY;
          ch_next.throttle = TH_MIN;
          t_clear          = 1'b1;
        end
        ST_FLY: begin
          if (cmd_valid && cmd_ready) begin
            ch_next.throttle = cmd_throttle;
            ch_next.yaw      = cmd_yaw;
            ch_next.pitch    = cmd_pitch;
            ch_next.roll     = cmd_roll;
            t_clear          = 1'b1;
          end else if (t_done) begin
            state_next    = ST_FAILSAFE;
            ch_next.yaw   = NEUTRAL;
            ch_next.pitch = NEUTRAL;
            ch_next.roll  = NEUTRAL;
            t_load        = 1'b1;
            // Zero throttle preloads the divider to terminal so the first
            // FAILSAFE cycle is already a ramp tick and exits to IDLE.
            t_load_value  = (ch.throttle == TH_MIN) ? TC_RAMP : '0;
          end else begin
            t_enable = 1'b1;
          end
        end
        ST_FAILSAFE: begin
          if (t_done) begin
            t_clear = 1'b1;
            if (ch.throttle == TH_MIN) begin
              state_next = ST_IDLE;
              ch_next    = idle_chans(NEUTRAL);
            end else begin
              ch_next.throttle = ch.throttle - 8'd1;
            end
          end else begin
            t_enable = 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          ch_next    = idle_chans(NEUTRAL);
          t_clear    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      ch    <= idle_chans(NEUTRAL);
    end else begin
      state <= state_next;
      ch    <= ch_next;
    end
  end

  assign ch_throttle = ch.throttle;
  assign ch_yaw      = ch.yaw;
  assign ch_pitch    = ch.pitch;
  assign ch_roll     = ch.roll;
  assign armed       = (state == ST_FLY) || (state == ST_FAILSAFE);
  assign failsafe    = (state == ST_FAILSAFE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_remote_channel_sequencer.sv
// Bench for remote_channel_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a cycle-level reference model.
module tb_remote_channel_sequencer;

  localparam int ALOW  = 4;
  localparam int AHIGH = 3;
  localparam int TOUT  = 5;
  localparam int RDIV  = 2;

  logic       clock = 1'b0;
  logic       reset_n, on_pulse, off_pulse, cmd_valid;
  logic [7:0] cmd_throttle, cmd_yaw, cmd_pitch, cmd_roll;
  logic       cmd_ready, armed, failsafe;
  logic [7:0] ch_throttle, ch_yaw, ch_pitch, ch_roll;
  logic [2:0] state_dbg;

  remote_channel_sequencer #(
    .CNT_W              (26),
    .ARM_LOW_CYCLES     (ALOW),
    .ARM_HIGH_CYCLES    (AHIGH),
    .CMD_TIMEOUT_CYCLES (TOUT),
    .RAMP_DIV           (RDIV),
    .NEUTRAL            (8'd128)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .on_pulse     (on_pulse),
    .off_pulse    (off_pulse),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_throttle (cmd_throttle),
    .cmd_yaw      (cmd_yaw),
    .cmd_pitch    (cmd_pitch),
    .cmd_roll     (cmd_roll),
    .ch_throttle  (ch_throttle),
    .ch_yaw       (ch_yaw),
    .ch_pitch     (ch_pitch),
    .ch_roll      (ch_roll),
    .armed        (armed),
    .failsafe     (failsafe),
    .state_dbg    (state_dbg)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode numbers are the debug encoding, 'left' counts
  // down cycles remaining in a timed phase, 'idle' counts quiet FLY cycles.
  typedef struct packed {
    int mode; int left; int idle; int th; int yw; int pt; int rl;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(input mdl_t s, input logic rn, input logic on,
                                input logic off, input logic v, input logic [7:0] t,
                                input logic [7:0] y, input logic [7:0] p,
                                input logic [7:0] r);
    mdl_t n = s;
    if (!rn || off) begin
      n.mode = 0; n.th = 0; n.yw = 128; n.pt = 128; n.rl = 128;
      return n;
    end
    case (s.mode)
      0: if (on) begin n.mode = 1; n.left = ALOW; end
      1: begin
        n.left = s.left - 1;
        if (n.left == 0) begin n.mode = 2; n.left = AHIGH; n.th = 255; end
      end
      2: begin
        n.left = s.left - 1;
        if (n.left == 0) begin n.mode = 3; n.th = 0; end
      end
      3: begin n.mode = 4; n.idle = 0; end
      4: if (v) begin
        n.th = int'(t); n.yw = int'(y); n.pt = int'(p); n.rl = int'(r); n.idle = 0;
      end else begin
        n.idle = s.idle + 1;
        if (n.idle == TOUT) begin
          n.mode = 5; n.yw = 128; n.pt = 128; n.rl = 128;
          n.left = (s.th == 0) ? 1 : RDIV;
        end
      end
      5: begin
        n.left = s.left - 1;
        if (n.left == 0) begin
          if (s.th == 0) n.mode = 0;
          else begin n.th = s.th - 1; n.left = RDIV; end
        end
      end
      default: n.mode = 0;
    endcase
    return n;
  endfunction

  always @(posedge clock)
    m <= step(m, reset_n, on_pulse, off_pulse, cmd_valid,
              cmd_throttle, cmd_yaw, cmd_pitch, cmd_roll);

  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_state",    int'(state_dbg),   m.mode);
      chk("m_throttle", int'(ch_throttle), m.th);
      chk("m_yaw",      int'(ch_yaw),      m.yw);
      chk("m_pitch",    int'(ch_pitch),    m.pt);
      chk("m_roll",     int'(ch_roll),     m.rl);
      chk("m_armed",    int'(armed),       int'(m.mode == 4 || m.mode == 5));
      chk("m_failsafe", int'(failsafe),    int'(m.mode == 5));
      chk("m_ready",    int'(cmd_ready),   int'(m.mode == 4));
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(0, 7))
      0: return 8'd0;
      1: return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic send(input logic [7:0] t, input logic [7:0] y,
                      input logic [7:0] p, input logic [7:0] r);
    cmd_valid = 1'b1;
    cmd_throttle = t; cmd_yaw = y; cmd_pitch = p; cmd_roll = r;
    tick();
    cmd_valid = 1'b0;
  endtask

  // From IDLE: on_pulse, then 4 low / 3 full / 1 low, ending in FLY.
  task automatic arm_seq(input bit poke);
    int exp_th [8] = '{0, 0, 0, 0, 255, 255, 255, 0};
    int exp_st [8] = '{1, 1, 1, 1, 2, 2, 2, 3};
    on_pulse = 1'b1;
    tick();
    on_pulse = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("arm_throttle", int'(ch_throttle), exp_th[i]);
      chk("arm_state",    int'(state_dbg),   exp_st[i]);
      chk("arm_yaw",      int'(ch_yaw),      128);
      chk("arm_ready",    int'(cmd_ready),   0);
      if (poke) begin
        on_pulse  = (i < 3);
        cmd_valid = (i < 7);
        cmd_throttle = rnd_byte(); cmd_yaw = rnd_byte();
        cmd_pitch = rnd_byte(); cmd_roll = rnd_byte();
      end
      tick();
    end
    on_pulse = 1'b0;
    cmd_valid = 1'b0;
    chk("fly_state", int'(state_dbg), 4);
    chk("fly_armed", int'(armed),     1);
    chk("fly_ready", int'(cmd_ready), 1);
    chk("fly_pitch", int'(ch_pitch),  128);
  endtask

  initial begin
    int exp_fs [8] = '{3, 3, 2, 2, 1, 1, 0, 0};
    reset_n = 1'b0; on_pulse = 1'b0; off_pulse = 1'b0; cmd_valid = 1'b0;
    cmd_throttle = '0; cmd_yaw = '0; cmd_pitch = '0; cmd_roll = '0;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_state",    int'(state_dbg),   0);
    chk("rst_throttle", int'(ch_throttle), 0);
    chk("rst_roll",     int'(ch_roll),     128);
    chk("rst_ready",    int'(cmd_ready),   0);
    chk("rst_armed",    int'(armed),       0);
    reset_n = 1'b1;

    arm_seq(1'b0);

    send(8'd200, 8'd10, 8'd128, 8'd250);
    chk("pass_throttle", int'(ch_throttle), 200);
    chk("pass_yaw",      int'(ch_yaw),      10);
    chk("pass_roll",     int'(ch_roll),     250);
    tick();
    tick();
    chk("hold_throttle", int'(ch_throttle), 200);
    chk("hold_pitch",    int'(ch_pitch),    128);

    on_pulse = 1'b1;
    tick();
    on_pulse = 1'b0;
    chk("fly_on_state", int'(state_dbg),   4);
    chk("fly_on_thr",   int'(ch_throttle), 200);

    send(8'd3, 8'd7, 8'd9, 8'd11);
    repeat (4) tick();
    chk("wd_pre_state", int'(state_dbg), 4);
    chk("wd_pre_fs",    int'(failsafe),  0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("fs_throttle", int'(ch_throttle), exp_fs[i]);
      chk("fs_yaw",      int'(ch_yaw),      128);
      chk("fs_flag",     int'(failsafe),    1);
      chk("fs_ready",    int'(cmd_ready),   0);
      cmd_valid = 1'b1;
      cmd_throttle = rnd_byte(); cmd_yaw = rnd_byte();
      cmd_pitch = rnd_byte(); cmd_roll = rnd_byte();
      tick();
    end
    cmd_valid = 1'b0;
    chk("fs_end_state", int'(state_dbg), 0);
    chk("fs_end_armed", int'(armed),     0);

    arm_seq(1'b0);
    send(8'd50, 8'd60, 8'd70, 8'd80);
    repeat (4) tick();
    off_pulse = 1'b1; cmd_valid = 1'b1;
    cmd_throttle = 8'd99; cmd_yaw = 8'd1; cmd_pitch = 8'd2; cmd_roll = 8'd3;
    tick();
    off_pulse = 1'b0; cmd_valid = 1'b0;
    chk("prio_state",    int'(state_dbg),   0);
    chk("prio_throttle", int'(ch_throttle), 0);
    chk("prio_yaw",      int'(ch_yaw),      128);
    chk("prio_armed",    int'(armed),       0);

    on_pulse = 1'b1;
    tick();
    on_pulse = 1'b0;
    repeat (4) tick();
    chk("mid_high_thr",   int'(ch_throttle), 255);
    chk("mid_high_state", int'(state_dbg),   2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_thr",   int'(ch_throttle), 0);
    chk("mid_rst_state", int'(state_dbg),   0);
    arm_seq(1'b1);

    send(8'd0, 8'd255, 8'd0, 8'd255);
    chk("zero_thr", int'(ch_throttle), 0);
    chk("max_yaw",  int'(ch_yaw),      255);
    repeat (5) tick();
    chk("zero_fs_state", int'(state_dbg), 5);
    tick();
    chk("zero_fs_exit", int'(state_dbg), 0);

    for (int i = 0; i < 4000; i++) begin
      reset_n   = ($urandom_range(0, 199) != 0);
      on_pulse  = ($urandom_range(0, 19) == 0);
      off_pulse = ($urandom_range(0, 149) == 0);
      cmd_valid = ($urandom_range(0, 9) < 2);
      cmd_throttle = rnd_byte(); cmd_yaw = rnd_byte();
      cmd_pitch = rnd_byte(); cmd_roll = rnd_byte();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/remote_channel_sequencer.md
Name: remote_channel_sequencer

Overview:
- Sequences and arbitrates the four 8-bit stick channels (throttle, yaw, pitch, roll) sent to the remote transmitter.
- On an on pulse, runs the arming pattern on throttle: low, full, low. It then passes gesture commands through a valid/ready handshake.
- Enforces a command watchdog, a throttle-ramp failsafe and disarm. It sits between the gesture decoder and the channel-to-PWM/DAC output stage.

Parameters:
- CNT_W, 26, width of the phase/timeout counter.
- ARM_LOW_CYCLES, 28000000, cycles throttle is held at 0 before the arm stroke.
- ARM_HIGH_CYCLES, 26000000, cycles throttle is held at 255 for the arm stroke.
- CMD_TIMEOUT_CYCLES, 13500000, idle cycles in FLY before failsafe.
- RAMP_DIV, 270000, cycles per 1-LSB throttle decrement in failsafe.
- NEUTRAL, 8'd128, centre value for yaw, pitch and roll.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- on_pulse  in  1  one-cycle arm request.
- off_pulse  in  1  one-cycle disarm request.
- cmd_valid  in  1  gesture command valid.
- cmd_ready  out  1  block accepts a command this cycle.
- cmd_throttle  in  8  commanded throttle.
- cmd_yaw  in  8  commanded yaw.
- cmd_pitch  in  8  commanded pitch.
- cmd_roll  in  8  commanded roll.
- ch_throttle  out  8  throttle channel output (registered).
- ch_yaw  out  8  yaw channel output (registered).
- ch_pitch  out  8  pitch channel output (registered).
- ch_roll  out  8  roll channel output (registered).
- armed  out  1  high in FLY and FAILSAFE.
- failsafe  out  1  high in FAILSAFE.
- state_dbg  out  3  current state encoding.

Behaviour:
- All logic is on the rising edge of clock. reset_n=0 sampled at an edge forces, on that edge:
  - state=IDLE, counter=0;
  - ch_throttle=0, ch_yaw=ch_pitch=ch_roll=NEUTRAL;
  - armed=0, failsafe=0, cmd_ready=0.
- Reset mid-sequence aborts immediately with no ramp.
- States are IDLE(0), ARM_LOW(1), ARM_HIGH(2), ARM_REL(3), FLY(4), FAILSAFE(5).
- IDLE:
  - outputs are at reset values;
  - on_pulse moves to ARM_LOW with counter cleared.
- ARM_LOW:
  - throttle=0; counter increments;
  - when counter==ARM_LOW_CYCLES-1, moves to ARM_HIGH with counter=0.
- ARM_HIGH:
  - throttle=255;
  - when counter==ARM_HIGH_CYCLES-1, moves to ARM_REL.
- ARM_REL:
  - throttle=0 for exactly one cycle, then FLY with counter=0.
- Arming channels:
  - yaw, pitch and roll stay at NEUTRAL throughout arming;
  - on_pulse is ignored in every state except IDLE.
- FLY:
  - armed=1, cmd_ready=1.
  - Handshake cmd_valid&&cmd_ready registers all four cmd_* into ch_* (1-cycle latency) and clears the counter.
  - Otherwise the counter increments. When counter==CMD_TIMEOUT_CYCLES-1, moves to FAILSAFE and holds the current ch_throttle.
- FAILSAFE:
  - cmd_ready=0, failsafe=1;
  - yaw, pitch and roll are forced to NEUTRAL on entry;
  - throttle decrements by 1 every RAMP_DIV cycles, saturating at 0;
  - when ch_throttle==0 at a ramp tick, or on entry with throttle already 0, moves to IDLE;
  - there is no re-arm without a fresh on_pulse from IDLE.
- off_pulse in any non-IDLE state moves to IDLE next cycle with outputs at reset values.
- off_pulse has priority over on_pulse, cmd_valid and timeout in the same cycle.
- Counter widths and comparisons are unsigned CNT_W; parameters must fit in CNT_W (elaboration check).
- Command values are passed unmodified, with no clamping; 0 and 255 are legal.
- cmd_ready is combinational from state only and never depends on cmd_valid.

Decomposition:
- Shared package remote_pkg holds:
  - the state enum/localparams;
  - NEUTRAL, TH_MIN=0 and TH_MAX=255;
  - default timing constants for the 27 MHz clock.
- One natural sub-module, phase_timer: a loadable CNT_W counter with clear, enable and terminal-count output. It is reused for the arm phases, the watchdog and the ramp divider.

Test Plan:
All scenarios use ARM_LOW_CYCLES=4, ARM_HIGH_CYCLES=3, CMD_TIMEOUT_CYCLES=5, RAMP_DIV=2.
1. Arm: reset_n low 2 cycles, then on_pulse -> ch_throttle=0 for 4 cycles, 255 for 3, 0 for 1; then armed=1, cmd_ready=1, with yaw/pitch/roll=128 throughout.
2. Command passthrough: in FLY, cmd_valid with {200,10,128,250} -> ch_* equal those values one cycle later. With cmd_valid held low, outputs hold.
3. Watchdog: in FLY with ch_throttle=3, no cmd_valid for 5 cycles -> failsafe=1, yaw/pitch/roll=128, throttle 3->2->1->0 every 2 cycles, then IDLE with armed=0.
4. Priority: off_pulse, cmd_valid and the timeout terminal count in the same cycle -> IDLE next cycle, throttle=0, command not latched.
5. Reset mid-ARM_HIGH (throttle=255): reset_n=0 for one edge -> throttle=0, state=IDLE that edge; a later on_pulse restarts the full 4/3/1 sequence.
6. Ignored requests: on_pulse during ARM_LOW and FLY -> no sequence restart. cmd_valid during arming and FAILSAFE -> cmd_ready=0, ch_* unchanged.
